// File: rtl/an_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : an_encoder_seq
//  Purpose  : Sequential AN-code encoder. Accepts an NW-bit data word N and
//             produces the CW-bit arithmetic codeword A*N with an iterative
//             shift-add multiplier that consumes one data bit per clock.
//             An optional single-bit error can be injected into the codeword
//             so the output can exercise AN decoders.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1   clock, rising edge
//    rst       in   1   asynchronous active-high reset
//    in_valid  in   1   data word offered
//    in_ready  out  1   encoder idle and able to accept
//    in_data   in   NW  data word N
//    inj_en    in   1   request single-bit error injection (sampled with data)
//    inj_pos   in   PW  bit index to flip (sampled with data)
//    out_valid out  1   codeword available
//    out_ready in   1   consumer accepts codeword
//    out_data  out  CW  codeword A*N, possibly with one bit flipped
//    out_inj   out  1   a bit flip was applied to out_data
//    busy      out  1   multiplying or holding a result
// ============================================================================
module an_encoder_seq #(
  parameter int A  = 13,
  parameter int NW = 8,
  parameter int CW = 12,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_data,
  input  logic          inj_en,
  input  logic [PW-1:0] inj_pos,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic          out_inj,
  output logic          busy
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (((A % 2) == 0) || (A <= 1)) begin : g_chk_a
      $error("an_encoder_seq: A must be odd and greater than 1");
    end
    // The largest codeword A*(2^NW-1) must fit in CW bits, otherwise the
    // truncating accumulator would silently wrap.
    if ((longint'(A) * ((longint'(1) << NW) - 1)) > ((longint'(1) << CW) - 1))
    begin : g_chk_cw
      $error("an_encoder_seq: CW too narrow for A*(2^NW-1)");
    end
    if ((longint'(1) << PW) < longint'(CW)) begin : g_chk_pw
      $error("an_encoder_seq: PW too narrow to address every codeword bit");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNTW = $clog2(NW + 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_MUL  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [CNTW-1:0] c_CNT_LAST = CNTW'(NW - 1);
  localparam logic [CNTW-1:0] c_CNT_ONE  = CNTW'(1);
  localparam logic [CW-1:0]   c_A_CW     = CW'(A);
  localparam logic [CW-1:0]   c_ONE_CW   = CW'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [NW-1:0]   r_n;        // remaining multiplier bits, LSB is current
  logic [CW-1:0]   r_mult;     // A << i for the bit currently processed
  logic [CW-1:0]   r_acc;
  logic [CNTW-1:0] r_cnt;
  logic            r_inj_en;
  logic [PW-1:0]   r_inj_pos;
  logic            r_out_valid;
  logic [CW-1:0]   r_out_data;
  logic            r_out_inj;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_addend;
  logic [CW-1:0] w_acc_next;
  logic          w_last;
  logic          w_pos_ok;
  logic [CW-1:0] w_mask;

  // Instead of indexing N by the counter, N shifts right and A shifts left,
  // so bit i of N always lines up with A << i at bit 0 / in r_mult.
  assign w_addend   = r_n[0] ? r_mult : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_last     = (r_cnt == c_CNT_LAST);

  // Positions past the codeword width are a legal request that yields no flip.
  assign w_pos_ok   = (32'(r_inj_pos) < 32'(CW));
  assign w_mask     = (r_inj_en && w_pos_ok) ? (c_ONE_CW << r_inj_pos) : '0;

  // --------------------------------------------------------------------------
  // Control FSM and registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_n         <= '0;
      r_mult      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_inj_en    <= 1'b0;
      r_inj_pos   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_inj   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (in_valid) begin
            r_n       <= in_data;
            r_mult    <= c_A_CW;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_inj_en  <= inj_en;
            r_inj_pos <= inj_pos;
            r_state   <= c_ST_MUL;
          end
        end

        c_ST_MUL: begin
          r_acc  <= w_acc_next;
          r_n    <= r_n >> 1;
          r_mult <= r_mult << 1;
          r_cnt  <= r_cnt + c_CNT_ONE;
          if (w_last) begin
            // The final partial product is folded in on the same edge that
            // publishes the result, so latency is exactly NW clocks.
            r_out_data  <= w_acc_next ^ w_mask;
            r_out_inj   <= |w_mask;
            r_out_valid <= 1'b1;
            r_state     <= c_ST_DONE;
          end
        end

        c_ST_DONE: begin
          // out_data/out_inj keep their value after handoff; only out_valid
          // qualifies them.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= c_ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= c_ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: in_ready/busy decode the state only, never out_ready.
  // --------------------------------------------------------------------------
  assign in_ready  = (r_state == c_ST_IDLE);
  assign busy      = (r_state == c_ST_MUL) || (r_state == c_ST_DONE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_inj   = r_out_inj;

endmodule
`default_nettype wire

// File: doc/an_encoder_seq.md
Name: an_encoder_seq

Overview:
- Sequential AN-code encoder: accepts an NW-bit data word N and produces the CW-bit arithmetic codeword A*N using an iterative shift-add multiplier, one data bit per clock.
- Transmit-side counterpart of the ANdecoder: its codewords (optionally with one injected bit error) drive decoder benches and datapaths.
- Valid/ready handshake on both sides; one word in flight at a time.

Parameters:
- A, 13, AN code constant (odd, >1).
- NW, 8, data word width.
- CW, 12, codeword width; elaboration error if A*(2^NW-1) > 2^CW-1.
- PW, 4, width of the error-injection position field; must satisfy 2^PW >= CW.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data word offered.
- in_ready  output  1  encoder idle and able to accept.
- in_data  input  NW  data word N.
- inj_en  input  1  request single-bit error injection for this word; sampled with in_data.
- inj_pos  input  PW  bit index to flip; sampled with in_data.
- out_valid  output  1  codeword available.
- out_ready  input  1  consumer accepts codeword.
- out_data  output  CW  codeword A*N, possibly with one bit flipped.
- out_inj  output  1  a bit flip was applied to out_data.
- busy  output  1  high in MUL or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_inj=0, busy=0, internal accumulator/counter/registers=0. Reset asserted mid-MUL or in DONE aborts the word immediately with no output.
- States: IDLE, MUL, DONE.
- IDLE: in_ready=1. An edge with in_valid=1 is the accept edge E0. It registers in_data, inj_en, inj_pos, clears the accumulator (CW bits) and the bit counter, and goes to MUL. in_ready is low from the next cycle.
- MUL: edge Ek, k=1..NW, processes bit i=k-1. If N[i]=1: acc <= acc + (A << i), truncated to CW bits; the parameter check guarantees no overflow.
  - On edge E_NW, the state goes to DONE.
  - On the same edge, out_data <= final acc XOR mask, where mask = (1 << inj_pos) if inj_en=1 and inj_pos < CW, else 0.
  - On the same edge, out_inj <= 1 if the mask is non-zero, else 0.
  - out_valid <= 1.
- Latency: out_valid rises exactly NW clocks after the accept edge.
- in_valid/in_data are ignored outside IDLE.
- DONE: out_valid=1. out_data and out_inj are held stable while out_ready=0, with no limit on back-pressure duration.
  - The edge with out_ready=1 completes the transfer: next state is IDLE, out_valid <= 0.
  - out_data and out_inj retain their last value; they are valid only while out_valid=1.
- in_ready does not depend combinationally on out_ready. Earliest next accept is the cycle after output handoff. Peak throughput is one word per NW+2 clocks.
- inj_en=1 with inj_pos >= CW: no flip, out_inj=0.
- N=0 gives codeword 0. N=2^NW-1 gives A*(2^NW-1).
- No combinational path from inputs to outputs; all outputs are registered except in_ready and busy, which decode the state register.

Test Plan:
- Reset, then in_data=11, inj_en=0, out_ready=1 -> out_valid rises 8 clocks after accept, out_data=143, out_inj=0; in_ready returns 1 the cycle after handoff.
- in_data=11 with inj_pos in turn 4, 5, 6, 8, 9, 10, 11 and inj_en=1 -> out_data respectively 159, 175, 207, 399, 655, 1167, 2191, out_inj=1 each; feed each into ANdecoder and check Nc=11.
- Boundaries: in_data=0 -> 0; in_data=255 -> 3315; in_data=1 -> 13. inj_en=1 with inj_pos=12 or 15 -> unflipped codeword, out_inj=0.
- Back-pressure: hold out_ready=0 for 20 cycles with in_valid=1 and changing in_data -> out_data stable, in_ready=0, no new accept. Release -> one handoff, then the pending in_data is accepted.
- Reset mid-MUL (rst pulsed 3 cycles after accept) -> out_valid never rises, in_ready=1 right after reset; the next word (in_data=7) encodes to 91.
- Random soak: 1000 words with random in_valid/out_ready gaps -> every out_data equals A*N XOR expected mask, in order, with no drops or duplicates.
